vga_digit_overlay: RTL
======================

# vga_digit_overlay

Parametrised pixel renderer for the RTC display. It draws ROWS rows of DIGITS BCD digits, grouped in pairs with separators, as procedural 7-segment glyphs, so no glyph ROM is needed. It adds a blinking edit cursor, an alarm background flash and frame-synchronous input latching. It sits between the sync generator (ADDRH/ADDRV) and the VGA colour pins, and replaces the fixed-layout selector/ROM path.

## Interface
- ROWS, 3, number of digit rows (date, time, timer)
- DIGITS, 6, digits per row; must be even (pairs)
- DIG_W, 32, glyph cell width in pixels
- DIG_H, 64, glyph cell height in pixels; must be even
- SEG_T, 4, segment thickness in pixels; must be even
- X0, 96, left x of digit 0
- Y0, 64, top y of row 0
- ROW_PITCH, 128, vertical distance between row tops
- PAIR_GAP, 32, horizontal gap between digit pairs; holds the separator
- SEP_MODE, 3'b110, bit r: 1 = colon on row r, 0 = slash on row r
- BLINK_FRAMES, 30, frames per blink half-period
- FG, 12'hFFF, digit and separator colour
- BG, 12'h000, background colour
- ALARM_BG, 12'h800, background colour during the alarm flash phase

Ports:
- CLK  in  1  pixel-domain clock
- RST  in  1  synchronous, active-low reset
- PIX_EN  in  1  coordinate strobe; the pipeline advances only when it is 1
- ADDRH  in  10  current pixel x
- ADDRV  in  10  current pixel y
- ACTIVE  in  1  coordinate lies in the visible area
- FIELDS  in  ROWS*DIGITS*4  BCD nibbles; row r, digit d at bits [4*(r*DIGITS+d) +: 4]; digit 0 is leftmost
- EDIT_EN  in  1  edit cursor enable
- EDIT_ROW  in  $clog2(ROWS)  row of the edited pair
- EDIT_PAIR  in  $clog2(DIGITS/2)  pair index within that row
- ALARM  in  1  alarm flash request
- COLOR_OUT  out  12  RGB444 pixel
- VALID_OUT  out  1  ACTIVE delayed by the pipeline
- FRAME_TICK  out  1  one-cycle pulse per frame

## Operation
- Frame start is the cycle where PIX_EN=1, ADDRH=0 and ADDRV=0.
- On frame start the block latches FIELDS, EDIT_EN, EDIT_ROW, EDIT_PAIR and ALARM into shadow registers. All rendering uses the shadow registers, so no mid-frame tearing occurs.
- Blink counter runs 0..BLINK_FRAMES-1 and increments on each frame start. When it wraps to 0, blink_phase toggles.
- Geometry:
  - Row r occupies y in [Y0+r*ROW_PITCH, +DIG_H).
  - Digit d starts at x = X0 + d*DIG_W + (d>>1)*PAIR_GAP.
  - The gap after pair p<DIGITS/2-1 holds a separator.
  - Local coordinates lx, ly are measured from the cell origin.
- Segments:
  - a: ly<SEG_T
  - d: ly>=DIG_H-SEG_T
  - g: DIG_H/2-SEG_T/2 <= ly < DIG_H/2+SEG_T/2
  - f, e: lx<SEG_T, upper half (ly<DIG_H/2) and lower half respectively
  - b, c: lx>=DIG_W-SEG_T, upper half and lower half respectively
  - Standard 7-segment decode of 0-9. Nibbles A-F render blank.
- Colon: two SEG_T×SEG_T squares centred horizontally in the gap, with tops at DIG_H/3 and 2*DIG_H/3.
- Slash: lit where |gx - (DIG_H-1-gy)/2| < SEG_T/2, with gx, gy local to the gap.
- Cursor: when shadow EDIT_EN=1 and blink_phase=1, both digits of the selected pair render as background. Separators are unaffected.
- Background is ALARM_BG when shadow ALARM=1 and blink_phase=1, otherwise BG.
- Any pixel with ACTIVE=0 outputs 12'h000.
- Priority per pixel: inactive > lit segment/separator (FG) > background.

## Timing
- Pipeline stages:
  - S1: region decode, local coordinates, frame-start detect.
  - S2: segment and separator hit test against the latched nibble.
  - S3: colour mux into a register.
- Latency is 3 PIX_EN strobes from coordinate to COLOR_OUT/VALID_OUT. All stages hold when PIX_EN=0.
- FRAME_TICK is registered. It is high for exactly one CLK cycle in the cycle after a frame-start strobe.
- Shadow registers and the blink counter update in that same cycle. The first pixel of a frame already renders with the new values.
- Reset (RST=0 at an edge) clears:
  - COLOR_OUT=0, VALID_OUT=0, FRAME_TICK=0
  - pipeline registers
  - shadow FIELDS=0 (displays "00"), shadow EDIT_EN and ALARM = 0
  - blink counter and blink_phase = 0
- Reset mid-frame: output stays black, with VALID_OUT=0, until pixels refill the pipeline.
- Changing FIELDS or EDIT_* mid-frame has no visible effect until the next frame start.
- Frame start when the blink counter is at BLINK_FRAMES-1: the counter wraps and blink_phase toggles in the same cycle.

## Test plan
- Reset: hold RST=0 for 5 cycles, then release. Required: COLOR_OUT=000, VALID_OUT=0, FRAME_TICK=0. First frame shows "00" everywhere.
- Render: FIELDS row 1 = 12:34:56. Pixel (X0+DIG_W+SEG_T, Y0+ROW_PITCH+1), i.e. the "2" a segment, -> FG three strobes later. Pixel (X0+2, Y0+ROW_PITCH+DIG_H/2+SEG_T), i.e. the "1" e segment, -> BG.
- Separators: with default SEP_MODE, check the gap pixel at the colon square on row 1 -> FG. Check the slash midpoint of row 0 gap 0 -> FG.
- Latching: change FIELDS mid-frame. Required: the old digit persists until the next FRAME_TICK and the new digit appears on the following frame.
- Blink: EDIT_EN=1, EDIT_ROW=2, EDIT_PAIR=1. Over 60 frames the pair is visible for frames 0-29 and blank for frames 30-59. Other pairs are always visible.
- Alarm: ALARM=1. A background pixel alternates BG/ALARM_BG every 30 frames. An ACTIVE=0 pixel stays 000. Nibble 4'hA renders blank.

Source files
------------

// File: rtl/vga_digit_overlay.sv
// vga_digit_overlay: procedural 7-segment renderer for ROWS x DIGITS BCD digits with separators, blink cursor and alarm flash
module vga_digit_overlay #(
    parameter int              ROWS         = 3,
    parameter int              DIGITS       = 6,
    parameter int              DIG_W        = 32,
    parameter int              DIG_H        = 64,
    parameter int              SEG_T        = 4,
    parameter int              X0           = 96,
    parameter int              Y0           = 64,
    parameter int              ROW_PITCH    = 128,
    parameter int              PAIR_GAP     = 32,
    parameter logic [ROWS-1:0] SEP_MODE     = 3'b110,
    parameter int              BLINK_FRAMES = 30,
    parameter logic [11:0]     FG           = 12'hFFF,
    parameter logic [11:0]     BG           = 12'h000,
    parameter logic [11:0]     ALARM_BG     = 12'h800,
    localparam int             RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int             PW           = (DIGITS > 2) ? $clog2(DIGITS / 2) : 1,
    localparam int             DW           = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int             BW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pix_en_i,
    input  logic [9:0]                 addrh_i,
    input  logic [9:0]                 addrv_i,
    input  logic                       active_i,
    input  logic [ROWS*DIGITS*4-1:0]   fields_i,
    input  logic                       edit_en_i,
    input  logic [RW-1:0]              edit_row_i,
    input  logic [PW-1:0]              edit_pair_i,
    input  logic                       alarm_i,
    output logic [11:0]                color_out_o,
    output logic                       valid_out_o,
    output logic                       frame_tick_o
);
    logic                     frame_start;
    logic                     frame_tick_q;
    logic [ROWS*DIGITS*4-1:0] sh_fields_q;
    logic                     sh_edit_en_q;
    logic [RW-1:0]            sh_edit_row_q;
    logic [PW-1:0]            sh_edit_pair_q;
    logic                     sh_alarm_q;
    logic [BW-1:0]            blink_cnt_q;
    logic                     blink_phase_q;
    logic                     blink_wrap;

    int                       px, py;
    logic                     row_hit, dig_hit, sep_hit;
    logic [RW-1:0]            row_d;
    logic [DW-1:0]            col_d;
    logic [9:0]               lx_d, ly_d;
    logic                     s1_act_q, s1_dig_q, s1_sep_q;
    logic [RW-1:0]            s1_row_q;
    logic [DW-1:0]            s1_col_q;
    logic [9:0]               s1_lx_q, s1_ly_q;

    int                       lx, ly, sd;
    logic [3:0]               nib;
    logic [6:0]               segs, zone;
    logic                     cursor, colon, slash, lit_d;
    logic                     s2_act_q, s2_lit_q, s2_alarm_q;

    logic [11:0]              color_q;
    logic                     valid_q;

    // Segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles stay dark
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    assign frame_start  = pix_en_i && addrh_i == '0 && addrv_i == '0;
    assign blink_wrap   = blink_cnt_q == BW'(BLINK_FRAMES - 1);
    assign color_out_o  = color_q;
    assign valid_out_o  = valid_q;
    assign frame_tick_o = frame_tick_q;

    // Latch per-frame inputs and advance the blink timer at frame start
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_tick_q   <= 1'b0;
            sh_fields_q    <= '0;
            sh_edit_en_q   <= 1'b0;
            sh_edit_row_q  <= '0;
            sh_edit_pair_q <= '0;
            sh_alarm_q     <= 1'b0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
        end else begin
            frame_tick_q <= frame_start;
            if (frame_start) begin
                sh_fields_q    <= fields_i;
                sh_edit_en_q   <= edit_en_i;
                sh_edit_row_q  <= edit_row_i;
                sh_edit_pair_q <= edit_pair_i;
                sh_alarm_q     <= alarm_i;
                blink_cnt_q    <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
                blink_phase_q  <= blink_phase_q ^ blink_wrap;
            end
        end
    end

    // Locate the pixel: which row, which digit cell or separator gap, and its local offset
    always_comb begin
        px      = int'(addrh_i);
        py      = int'(addrv_i);
        row_hit = 1'b0;
        dig_hit = 1'b0;
        sep_hit = 1'b0;
        row_d   = '0;
        col_d   = '0;
        lx_d    = '0;
        ly_d    = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (py >= Y0 + r * ROW_PITCH && py < Y0 + r * ROW_PITCH + DIG_H) begin
                row_hit = 1'b1;
                row_d   = RW'(r);
                ly_d    = 10'(py - Y0 - r * ROW_PITCH);
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (px >= X0 + d * DIG_W + (d / 2) * PAIR_GAP && px < X0 + d * DIG_W + (d / 2) * PAIR_GAP + DIG_W) begin
                dig_hit = 1'b1;
                col_d   = DW'(d);
                lx_d    = 10'(px - X0 - d * DIG_W - (d / 2) * PAIR_GAP);
            end
        end
        for (int p = 0; p < DIGITS / 2 - 1; p++) begin
            if (px >= X0 + (2 * p + 2) * DIG_W + p * PAIR_GAP && px < X0 + (2 * p + 2) * DIG_W + (p + 1) * PAIR_GAP) begin
                sep_hit = 1'b1;
                lx_d    = 10'(px - X0 - (2 * p + 2) * DIG_W - p * PAIR_GAP);
            end
        end
    end

    // S1: register region decode
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_act_q <= 1'b0;
            s1_dig_q <= 1'b0;
            s1_sep_q <= 1'b0;
            s1_row_q <= '0;
            s1_col_q <= '0;
            s1_lx_q  <= '0;
            s1_ly_q  <= '0;
        end else if (pix_en_i) begin
            s1_act_q <= active_i;
            s1_dig_q <= row_hit && dig_hit;
            s1_sep_q <= row_hit && sep_hit;
            s1_row_q <= row_d;
            s1_col_q <= col_d;
            s1_lx_q  <= lx_d;
            s1_ly_q  <= ly_d;
        end
    end

    // Hit test: segment zones of the shadow nibble, colon squares or slash band in the gap
    always_comb begin
        lx     = int'(s1_lx_q);
        ly     = int'(s1_ly_q);
        nib    = sh_fields_q[4 * (int'(s1_row_q) * DIGITS + int'(s1_col_q)) +: 4];
        segs   = seg_decode(nib);
        zone   = {ly < SEG_T,
                  lx >= DIG_W - SEG_T && ly < DIG_H / 2,
                  lx >= DIG_W - SEG_T && ly >= DIG_H / 2,
                  ly >= DIG_H - SEG_T,
                  lx < SEG_T && ly >= DIG_H / 2,
                  lx < SEG_T && ly < DIG_H / 2,
                  ly >= DIG_H / 2 - SEG_T / 2 && ly < DIG_H / 2 + SEG_T / 2};
        cursor = sh_edit_en_q && blink_phase_q && s1_row_q == sh_edit_row_q && PW'(s1_col_q >> 1) == sh_edit_pair_q;
        colon  = lx >= (PAIR_GAP - SEG_T) / 2 && lx < (PAIR_GAP - SEG_T) / 2 + SEG_T &&
                 ((ly >= DIG_H / 3 && ly < DIG_H / 3 + SEG_T) || (ly >= 2 * DIG_H / 3 && ly < 2 * DIG_H / 3 + SEG_T));
        sd     = lx - (DIG_H - 1 - ly) / 2;
        slash  = sd > -(SEG_T / 2) && sd < SEG_T / 2;
        lit_d  = (s1_dig_q && !cursor && |(segs & zone)) || (s1_sep_q && (SEP_MODE[s1_row_q] ? colon : slash));
    end

    // S2: register hit result; background choice is fixed here so a pixel never mixes two frames
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_act_q   <= 1'b0;
            s2_lit_q   <= 1'b0;
            s2_alarm_q <= 1'b0;
        end else if (pix_en_i) begin
            s2_act_q   <= s1_act_q;
            s2_lit_q   <= lit_d;
            s2_alarm_q <= sh_alarm_q && blink_phase_q;
        end
    end

    // S3: colour mux, inactive forces black
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            color_q <= 12'h000;
            valid_q <= 1'b0;
        end else if (pix_en_i) begin
            color_q <= !s2_act_q ? 12'h000 : s2_lit_q ? FG : s2_alarm_q ? ALARM_BG : BG;
            valid_q <= s2_act_q;
        end
    end
endmodule
